// File: rtl/sar_adc_scan_ctrl.sv
`timescale 1ns/1ps
// sar_adc_scan_ctrl
// Scan controller for a 12-bit SAR ADC. While idle the ADC is held in reset.
// A scan start latches the channel mask and rate code, releases the ADC after
// a short reset window, then steps the analog mux through the enabled
// channels, one per ADC frame, using the ADC data-ready strobe. Each result is
// tagged with its channel and queued in a 2-entry valid/ready buffer.
//
// Ports:
//   CLK, RSTN         clock (posedge) and asynchronous active-low reset
//   EN                level: 1 = scan, 0 = stop
//   CH_MASK           channel enable mask, latched at scan start
//   RATE_CFG          sample-rate code, latched to SAMP_RATE_MUX at scan start
//   ADC_DR, ADC_DATA  ADC data-ready (high while converting) and result
//   OUT_READY         downstream ready
//   OVF_CLR           one-cycle pulse clearing OVERFLOW
//   ADC_RSTN          ADC reset, active low (high only while scanning)
//   SAMP_RATE_MUX     latched rate code
//   CH_SEL            analog mux select
//   OUT_VALID/DATA/CH buffer head
//   SCAN_DONE         pulse: result of the highest enabled channel arrived
//   OVERFLOW          sticky: a result was dropped on a full buffer
//   BUSY              controller not idle
module sar_adc_scan_ctrl #(
  parameter int NCH = 8,
  parameter int CHW = 3,
  parameter int DW  = 12
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           EN,
  input  logic [NCH-1:0] CH_MASK,
  input  logic [1:0]     RATE_CFG,
  input  logic           ADC_DR,
  input  logic [DW-1:0]  ADC_DATA,
  input  logic           OUT_READY,
  input  logic           OVF_CLR,
  output logic           ADC_RSTN,
  output logic [1:0]     SAMP_RATE_MUX,
  output logic [CHW-1:0] CH_SEL,
  output logic           OUT_VALID,
  output logic [DW-1:0]  OUT_DATA,
  output logic [CHW-1:0] OUT_CH,
  output logic           SCAN_DONE,
  output logic           OVERFLOW,
  output logic           BUSY
);

  typedef enum logic [1:0] {IDLE, START, RUN} state_t;

  state_t           state, state_next;
  logic             start_cnt;
  logic [NCH-1:0]   mask_q;
  logic [CHW-1:0]   ch_conv;
  logic             have_conv;
  logic             dr_q;

  logic [CHW-1:0]   start_ch;   // lowest enabled channel of the live mask
  logic [CHW-1:0]   lo_ch;      // lowest enabled channel of the latched mask
  logic [CHW-1:0]   hi_ch;      // highest enabled channel of the latched mask
  logic [CHW-1:0]   next_ch;    // next enabled channel above CH_SEL, wrapping
  logic             found;
  logic             run_act, rise, fall, wr_req;

  logic [CHW+DW-1:0] mem [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        count;
  logic              pop, full, wr_ok, drop;

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      start_cnt <= 1'b0;
    end else begin
      state     <= state_next;
      // Counts the two START cycles; cleared everywhere else.
      start_cnt <= (state == START) ? 1'b1 : 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (EN && (|CH_MASK)) state_next = START;
      START: begin
        if (!EN)            state_next = IDLE;
        else if (start_cnt) state_next = RUN;
      end
      RUN:     if (!EN) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ADC_RSTN = (state == RUN);
  assign BUSY     = (state != IDLE);

  // ---------------- channel search ----------------
  always_comb begin
    start_ch = '0;
    lo_ch    = '0;
    hi_ch    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (CH_MASK[i]) start_ch = CHW'(i);
      if (mask_q[i])  lo_ch    = CHW'(i);
    end
    for (int i = 0; i < NCH; i++) begin
      if (mask_q[i]) hi_ch = CHW'(i);
    end
  end

  // Nothing enabled above CH_SEL means wrap to the lowest; with a single
  // enabled channel that is CH_SEL itself.
  always_comb begin
    next_ch = lo_ch;
    found   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!found && mask_q[i] && (CHW'(i) > CH_SEL)) begin
        next_ch = CHW'(i);
        found   = 1'b1;
      end
    end
  end

  // Edges are only acted on while scanning and still enabled, so a frame
  // in flight when EN drops is abandoned.
  assign run_act = (state == RUN) && EN;
  assign rise    = run_act && !dr_q && ADC_DR;
  assign fall    = run_act && dr_q && !ADC_DR;
  assign wr_req  = fall && have_conv;

  // ---------------- scan datapath ----------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mask_q        <= '0;
      SAMP_RATE_MUX <= '0;
      CH_SEL        <= '0;
      ch_conv       <= '0;
      have_conv     <= 1'b0;
      dr_q          <= 1'b1;
      SCAN_DONE     <= 1'b0;
    end else begin
      SCAN_DONE <= 1'b0;
      if (state == IDLE && state_next == START) begin
        mask_q        <= CH_MASK;
        SAMP_RATE_MUX <= RATE_CFG;
        CH_SEL        <= start_ch;
        have_conv     <= 1'b0;
        dr_q          <= 1'b1;
      end else if (state == RUN) begin
        dr_q <= ADC_DR;
        if (rise) begin
          ch_conv   <= CH_SEL;
          have_conv <= 1'b1;
          CH_SEL    <= next_ch;
        end
        if (wr_req) SCAN_DONE <= (ch_conv == hi_ch);
      end
    end
  end

  // ---------------- 2-entry output buffer ----------------
  assign pop   = OUT_VALID && OUT_READY;
  assign full  = (count == 2'd2);
  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot wr_ptr points at, so the write can proceed.
  assign wr_ok = wr_req && (!full || pop);
  assign drop  = wr_req && full && !pop;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      OVERFLOW <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= {ch_conv, ADC_DATA};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, wr_ok} - {1'b0, pop};
      // Set has priority over clear.
      if (drop)         OVERFLOW <= 1'b1;
      else if (OVF_CLR) OVERFLOW <= 1'b0;
    end
  end

  assign OUT_VALID        = (count != 2'd0);
  assign {OUT_CH, OUT_DATA} = mem[rd_ptr];

endmodule
